// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one FIFO write port among N_REQ requesters in bursts.
// Optional statistics counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                        full,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            ack,
  output logic                        w_en,
  output logic [DATA_WIDTH-1:0]       w_data,
  output logic                        busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]         wr_count,
  output logic [15:0]                 stall_count
`endif
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
  localparam logic [PTR_W:0]   N_WRAP    = (PTR_W + 1)'(N_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] search_start;
  logic [PTR_W-1:0] found_idx;
  logic [PTR_W:0]   pos;
  logic [N_REQ-1:0] found_onehot;
  logic             found;
  logic             gnt_req;
  logic             release_gnt;

  always_comb begin
    gnt_idx = '0;
    w_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PTR_W'(i);
        w_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign gnt_req  = |(gnt & req);
  assign w_en     = gnt_req & ~full;
  assign ack      = gnt & {N_REQ{w_en}};
  assign busy     = |gnt;
  assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // A stalled burst keeps its grant; only a completed burst or a dropped request lets go.
  assign release_gnt  = (state == BUSY) && ((w_en && (beat_cnt == LAST_BEAT)) || !gnt_req);
  assign search_start = (state == BUSY) ? next_ptr : rr_ptr;

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    pos       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, search_start} + (PTR_W + 1)'(k);
      if (pos >= N_WRAP) pos = pos - N_WRAP;
      if (!found && req[pos[PTR_W-1:0]]) begin
        found     = 1'b1;
        found_idx = pos[PTR_W-1:0];
      end
    end
    found_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << found_idx;
  end

  // Searching from just past the releasing requester makes it the last candidate, so
  // a lone requester is simply re-granted without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= found_onehot;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_gnt) begin
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
            if (found) begin
              gnt <= found_onehot;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else if (w_en) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] wr_cnt [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) wr_cnt[i] <= '0;
      stall_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ack[i] && (wr_cnt[i] != 16'hFFFF)) wr_cnt[i] <= wr_cnt[i] + 16'd1;
      end
      if (busy && gnt_req && full && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

  always_comb begin
    wr_count = '0;
    for (int i = 0; i < N_REQ; i++) wr_count[i*16 +: 16] = wr_cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: scoreboard bench for fifo_wr_arb; expected writes are queued in arbitration order.
// Builds with or without FIFO_WR_ARB_STATS_EN; the counter scenario runs only when it is defined.
module tb_fifo_wr_arb;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_MAX  = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic                        full;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            ack;
  logic                        w_en;
  logic [DATA_WIDTH-1:0]       w_data;
  logic                        busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ*16-1:0]         wr_count;
  logic [15:0]                 stall_count;
`endif

  typedef struct packed {
    logic [N_REQ-1:0]      ack;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               failures = 0;
  int               remaining [N_REQ];
  int               sent [N_REQ];
  int               pushed [N_REQ];
  logic             full_next;
  logic [N_REQ-1:0] pend_ack;
  logic [N_REQ-1:0] last_gnt;
  logic             last_w_en;
  logic             last_busy;
  int               gaps;
  bit               write_seen;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .N_REQ(N_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .full(full),
    .gnt(gnt),
    .ack(ack),
    .w_en(w_en),
    .w_data(w_data),
    .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .wr_count(wr_count),
    .stall_count(stall_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] word_of(input int idx, input int n);
    return DATA_WIDTH'(idx * 64 + n);
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      req[i] = (remaining[i] > 0);
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = word_of(i, sent[i]);
    end
    full = full_next;
  endtask

  // Call order defines the expected write order in the scoreboard.
  task automatic applyStimulus(input int idx, input int count);
    exp_t e;
    remaining[idx] += count;
    for (int n = 0; n < count; n++) begin
      e.ack  = N_REQ'(1) << idx;
      e.data = word_of(idx, pushed[idx]);
      pushed[idx]++;
      exp_q.push_back(e);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (pend_ack[i]) begin
        sent[i]++;
        remaining[i]--;
      end
    end
    drive_inputs();
    @(negedge clk);
    last_gnt  = gnt;
    last_w_en = w_en;
    last_busy = busy;
    pend_ack  = '0;
    if (w_en) begin
      write_seen = 1'b1;
      checkOutput("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("w_data", w_data, e.data);
        checkOutput("ack", ack, e.ack);
      end
      pend_ack = ack;
    end else if (write_seen && exp_q.size() != 0) begin
      gaps++;
    end
  endtask

  function automatic bit pending();
    bit p = (exp_q.size() != 0) || (pend_ack != '0);
    for (int i = 0; i < N_REQ; i++) if (remaining[i] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    checkOutput("drain_timeout", pending(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_w_en", w_en, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_w_data", w_data, 0);
`ifdef FIFO_WR_ARB_STATS_EN
    checkOutput("rst_wr_count", wr_count, 0);
    checkOutput("rst_stall_count", stall_count, 0);
`endif
    for (int i = 0; i < N_REQ; i++) begin
      remaining[i] = 0;
      pushed[i]    = sent[i];
    end
    exp_q.delete();
    pend_ack   = '0;
    full_next  = 1'b0;
    gaps       = 0;
    write_seen = 1'b0;
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    full = 1'b0;
    full_next = 1'b0;
    pend_ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      remaining[i] = 0;
      sent[i]      = 0;
      pushed[i]    = 0;
    end
    #2;
    do_reset();

    // Idle after reset, then a single word from requester 2 with one-cycle grant latency.
    step();
    checkOutput("idle_gnt", last_gnt, 0);
    checkOutput("idle_w_en", last_w_en, 0);
    checkOutput("idle_busy", last_busy, 0);
    applyStimulus(2, 1);
    step();
    checkOutput("s1_gnt_before", last_gnt, 0);
    step();
    checkOutput("s1_gnt", last_gnt, 4'b0100);
    checkOutput("s1_w_en", last_w_en, 1);
    step();
    step();
    checkOutput("s1_released", last_busy, 0);

    // All four requesting: bursts of four in order 0,1,2,3,0,1,2,3 with no bubble.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_REQ; i++) applyStimulus(i, BURST_MAX);
    end
    drain(100);
    checkOutput("s2_no_bubble", gaps, 0);

    // Lone requester 1 streams ten words back-to-back across re-grants.
    do_reset();
    applyStimulus(1, 10);
    drain(60);
    checkOutput("s3_no_bubble", gaps, 0);

    // Full stall of three cycles after the second write of requester 0.
    do_reset();
    applyStimulus(0, 4);
    step();
    step();
    step();
    full_next = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("s4_stall_w_en", last_w_en, 0);
      checkOutput("s4_stall_gnt", last_gnt, 4'b0001);
    end
    full_next = 1'b0;
    step();
    checkOutput("s4_resume_w_en", last_w_en, 1);
    step();
    checkOutput("s4_resume_w_en2", last_w_en, 1);
    step();
    step();
    checkOutput("s4_released", last_busy, 0);
    checkOutput("s4_all_written", exp_q.size(), 0);

    // Requester 3 drops after one word; requester 1 takes over on the release edge.
    do_reset();
    applyStimulus(3, 1);
    step();
    applyStimulus(1, 2);
    step();
    checkOutput("s5_gnt3", last_gnt, 4'b1000);
    step();
    checkOutput("s5_gnt3_hold", last_gnt, 4'b1000);
    checkOutput("s5_hold_w_en", last_w_en, 0);
    step();
    checkOutput("s5_gnt1", last_gnt, 4'b0010);
    drain(20);

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    applyStimulus(2, 70000);
    step();
    step();
    step();
    full_next = 1'b1;
    for (int c = 0; c < 3; c++) step();
    full_next = 1'b0;
    drain(70100);
    step();
    step();
    checkOutput("stats_stall_count", stall_count, 3);
    checkOutput("stats_wr_count2", wr_count[2*16 +: 16], 16'hFFFF);
    checkOutput("stats_wr_count0", wr_count[15:0], 0);
`endif

    // Reset asserted in the middle of a burst drops the grant at once.
    do_reset();
    applyStimulus(2, 6);
    step();
    step();
    step();
    #2;
    do_reset();
    step();
    checkOutput("s6_idle_after", last_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
